// File: rtl/qq_pkg.sv
// ============================================================================
// qq_pkg : shared types and defaults for the QuickQ op scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package qq_pkg;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENQ  = 2'd1,
        S_DEQ  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int         DEF_DW         = 32;
    localparam int         DEF_DEPTH      = 7;
    localparam logic [7:0] DEF_ARRAY_SIZE = 8'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qq_rr_arbiter.sv
// ============================================================================
// qq_rr_arbiter : round-robin arbiter, priority starts at the pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module qq_rr_arbiter
    import qq_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] r_ptr;
    logic           w_found;

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                gnt_id   = IDW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

    // Pointer moves past every grant, accepted or rejected downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && (|req)) begin
            if (gnt_id == IDW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= gnt_id + IDW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/qq_op_scheduler.sv
// ============================================================================
// qq_op_scheduler : arbitrates client enqueue/dequeue requests onto QuickQ
// Rev 1.0
// ============================================================================
`default_nettype none

module qq_op_scheduler
    import qq_pkg::*;
#(
    parameter int         NREQ       = 4,
    parameter int         DW         = DEF_DW,
    parameter logic [7:0] ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int         DEPTH      = DEF_DEPTH,
    parameter int         ENQ_CYC    = 19,
    parameter int         DEQ_CYC    = 7,
    localparam int        IDW        = $clog2(NREQ),
    localparam int        CW         = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_data,
    output logic               q_enq,
    output logic               q_deq,
    output logic [DW-1:0]      q_data_lt,
    output logic [DW-1:0]      q_data_rt,
    output logic [7:0]         q_array_size,
    input  logic [DW-1:0]      q_data_lt_o,
    input  logic [DW-1:0]      q_data_rt_o,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    localparam int TW = $clog2(max_int(ENQ_CYC, DEQ_CYC) + 1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [TW-1:0]  r_cyc;
    logic [DW-1:0]  r_key;
    logic [DW-1:0]  r_rdata;
    logic [IDW-1:0] r_id;
    logic           r_err;
    logic [CW-1:0]  r_count;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_grant_en;
    logic            w_take;
    op_e             w_gnt_op;
    logic            unused_ok;

    // Reset also masks the combinational grant so nothing is offered during it
    assign w_grant_en = (r_state == S_IDLE) && !rst;
    assign w_take     = w_grant_en && (|req_valid);
    assign w_gnt_op   = op_e'(req_op[w_gnt_id]);

    qq_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (w_grant_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    if (w_gnt_op == OP_ENQ && !full) begin
                        w_state_nxt = S_ENQ;
                    end else if (w_gnt_op == OP_DEQ && !empty) begin
                        w_state_nxt = S_DEQ;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_ENQ, S_DEQ: begin
                if (r_cyc == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc   <= '0;
            r_key   <= '0;
            r_rdata <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_id    <= w_gnt_id;
                        r_key   <= req_data[w_gnt_id*DW +: DW];
                        r_err   <= (w_state_nxt == S_RESP);
                        r_rdata <= '0;
                        r_cyc   <= (w_state_nxt == S_ENQ) ? TW'(ENQ_CYC - 1)
                                                          : TW'(DEQ_CYC - 1);
                    end
                end
                S_ENQ: begin
                    if (r_cyc != '0) begin
                        r_cyc <= r_cyc - TW'(1);
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DEQ: begin
                    if (r_cyc != '0) begin
                        r_cyc <= r_cyc - TW'(1);
                    end else begin
                        r_rdata <= q_data_lt_o;
                        r_count <= r_count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = w_grant_en ? w_gnt : '0;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_id       = rsp_valid ? r_id : '0;
    assign rsp_err      = rsp_valid & r_err;
    assign rsp_data     = rsp_valid ? r_rdata : '0;
    assign q_enq        = (r_state == S_ENQ);
    assign q_deq        = (r_state == S_DEQ);
    assign q_data_lt    = r_key;
    assign q_data_rt    = DW'(r_id);
    assign q_array_size = ARRAY_SIZE;
    assign count        = r_count;
    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);

    // The queue's tag output is not needed: responses carry the requester id
    assign unused_ok = ^q_data_rt_o;

endmodule

`default_nettype wire
